// File: rtl/rocketcpu_bus_pkg.sv
// Shared types and constants for the three-master memory-bus scheduler.
package rocketcpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_IBUS = 2'd1;
  localparam owner_t OWN_DBUS = 2'd2;
  localparam owner_t OWN_DMA  = 2'd3;

  localparam int          DEF_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] DEF_ERR_DATA       = 32'h0000_0000;

endpackage

// File: rtl/rocketcpu_rr_pick.sv
// Combinational 3-way round-robin pick; the search starts just after the last owner.
module rocketcpu_rr_pick
  import rocketcpu_bus_pkg::*;
(
  input  logic [2:0] i_req,     // bit0 ibus, bit1 dbus, bit2 dma
  input  owner_t     i_last,
  output owner_t     o_winner
);

  always_comb begin
    o_winner = OWN_NONE;
    case (i_last)
      OWN_IBUS: begin
        if (i_req[1])      o_winner = OWN_DBUS;
        else if (i_req[2]) o_winner = OWN_DMA;
        else if (i_req[0]) o_winner = OWN_IBUS;
      end
      OWN_DBUS: begin
        if (i_req[2])      o_winner = OWN_DMA;
        else if (i_req[0]) o_winner = OWN_IBUS;
        else if (i_req[1]) o_winner = OWN_DBUS;
      end
      default: begin
        if (i_req[0])      o_winner = OWN_IBUS;
        else if (i_req[1]) o_winner = OWN_DBUS;
        else if (i_req[2]) o_winner = OWN_DMA;
      end
    endcase
  end

endmodule

// File: rtl/rocketcpu_bus_scheduler.sv
// Arbitrates ibus, dbus and audio DMA onto one Wishbone-style memory bus,
// with a dead cycle between transactions and a per-transaction ack timeout.
module rocketcpu_bus_scheduler
  import rocketcpu_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic        i_wb_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic [31:0] i_dma_adr,
  input  logic [31:0] i_dma_dat,
  input  logic [3:0]  i_dma_sel,
  input  logic        i_dma_we,
  input  logic        i_dma_cyc,
  output logic [31:0] o_dma_rdt,
  output logic        o_dma_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout,
  output logic [7:0]  o_timeout_cnt
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  owner_t      owner_q, owner_d;   // doubles as "last owner" once back in IDLE
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  tcnt_q, tcnt_d;

  owner_t      winner;
  logic [31:0] own_adr, own_dat;
  logic [3:0]  own_sel;
  logic        own_we, own_cyc;
  logic        live, timeout_hit, give_ack;
  logic [31:0] resp_rdt;

  rocketcpu_rr_pick u_rr_pick (
    .i_req    ({i_dma_cyc, i_dbus_cyc, i_ibus_cyc}),
    .i_last   (owner_q),
    .o_winner (winner)
  );

  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    case (owner_q)
      OWN_IBUS: begin
        own_adr = i_ibus_adr;
        own_sel = 4'hF;
        own_cyc = i_ibus_cyc;
      end
      OWN_DBUS: begin
        own_adr = i_dbus_adr;
        own_dat = i_dbus_dat;
        own_sel = i_dbus_sel;
        own_we  = i_dbus_we;
        own_cyc = i_dbus_cyc;
      end
      OWN_DMA: begin
        own_adr = i_dma_adr;
        own_dat = i_dma_dat;
        own_sel = i_dma_sel;
        own_we  = i_dma_we;
        own_cyc = i_dma_cyc;
      end
      default: ;
    endcase
  end

  // An abort (owner drops cyc) outranks both a slave ack and a timeout;
  // a real ack outranks a timeout landing in the same cycle.
  assign live        = (state_q == ST_BUSY) && own_cyc;
  assign timeout_hit = live && !i_wb_ack && (tmo_q == TMO_LAST);
  assign give_ack    = live && (i_wb_ack || timeout_hit);
  assign resp_rdt    = timeout_hit ? ERR_DATA : i_wb_rdt;

  assign o_wb_adr = own_adr;
  assign o_wb_dat = own_dat;
  assign o_wb_sel = own_sel;
  assign o_wb_we  = own_we;
  assign o_wb_cyc = live && !timeout_hit;

  assign o_ibus_ack = give_ack && (owner_q == OWN_IBUS);
  assign o_dbus_ack = give_ack && (owner_q == OWN_DBUS);
  assign o_dma_ack  = give_ack && (owner_q == OWN_DMA);
  assign o_ibus_rdt = (owner_q == OWN_IBUS) ? resp_rdt : i_wb_rdt;
  assign o_dbus_rdt = (owner_q == OWN_DBUS) ? resp_rdt : i_wb_rdt;
  assign o_dma_rdt  = (owner_q == OWN_DMA)  ? resp_rdt : i_wb_rdt;

  assign o_grant       = (state_q == ST_IDLE) ? OWN_NONE : owner_q;
  assign o_timeout     = timeout_hit;
  assign o_timeout_cnt = tcnt_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tmo_d   = tmo_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          state_d = ST_BUSY;
          owner_d = winner;
          tmo_d   = 8'd0;
        end
      end
      ST_BUSY: begin
        if (!own_cyc)      state_d = ST_IDLE;
        else if (give_ack) state_d = ST_RELEASE;
        else               tmo_d   = tmo_q + 8'd1;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (timeout_hit && (tcnt_q != 8'hFF)) tcnt_d = tcnt_q + 8'd1;
  end

  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_DMA;
      tmo_q   <= 8'd0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      tmo_q   <= tmo_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_rocketcpu_bus_scheduler.sv
// Directed bench for the bus scheduler: reset, single write, round-robin,
// timeout, ack-at-limit, abort and mid-transaction reset.
module tb_rocketcpu_bus_scheduler;

  logic        clk;
  logic        rst_n;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr, dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we, dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic [31:0] dma_adr, dma_dat;
  logic [3:0]  dma_sel;
  logic        dma_we, dma_cyc;
  logic [31:0] dma_rdt;
  logic        dma_ack;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [1:0]  grant;
  logic        timeout;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int errors = 0;

  rocketcpu_bus_scheduler #(
    .TIMEOUT_CYCLES (4),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .i_wb_clk      (clk),
    .i_rst_n       (rst_n),
    .i_ibus_adr    (ibus_adr),
    .i_ibus_cyc    (ibus_cyc),
    .o_ibus_rdt    (ibus_rdt),
    .o_ibus_ack    (ibus_ack),
    .i_dbus_adr    (dbus_adr),
    .i_dbus_dat    (dbus_dat),
    .i_dbus_sel    (dbus_sel),
    .i_dbus_we     (dbus_we),
    .i_dbus_cyc    (dbus_cyc),
    .o_dbus_rdt    (dbus_rdt),
    .o_dbus_ack    (dbus_ack),
    .i_dma_adr     (dma_adr),
    .i_dma_dat     (dma_dat),
    .i_dma_sel     (dma_sel),
    .i_dma_we      (dma_we),
    .i_dma_cyc     (dma_cyc),
    .o_dma_rdt     (dma_rdt),
    .o_dma_ack     (dma_ack),
    .o_wb_adr      (wb_adr),
    .o_wb_dat      (wb_dat),
    .o_wb_sel      (wb_sel),
    .o_wb_we       (wb_we),
    .o_wb_cyc      (wb_cyc),
    .i_wb_rdt      (wb_rdt),
    .i_wb_ack      (wb_ack),
    .o_grant       (grant),
    .o_timeout     (timeout),
    .o_timeout_cnt (timeout_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    dma_adr = '0; dma_dat = '0; dma_sel = '0; dma_we = 1'b0; dma_cyc = 1'b0;
    wb_rdt = '0; wb_ack = 1'b0;
    #2;
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL rst_cyc got %0b exp 0", wb_cyc); end
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d exp 0", grant); end
    checks++; if ({ibus_ack, dbus_ack, dma_ack} !== 3'b000) begin errors++; $display("FAIL rst_acks got %b exp 000", {ibus_ack, dbus_ack, dma_ack}); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout); end
    checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("FAIL rst_tcnt got %0d exp 0", timeout_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    $display("txn reset done");
  endtask

  task automatic test_single_write();
    dbus_adr = 32'h0000_0100; dbus_dat = 32'hCAFE_F00D; dbus_sel = 4'hF; dbus_we = 1'b1; dbus_cyc = 1'b1;
    #1;
    checks++; if (wb_cyc !== 1'b0 || grant !== 2'd0) begin errors++; $display("FAIL wr_arb got cyc %0b grant %0d exp cyc 0 grant 0", wb_cyc, grant); end
    step();
    checks++; if (wb_cyc !== 1'b1 || grant !== 2'd2) begin errors++; $display("FAIL wr_busy1 got cyc %0b grant %0d exp cyc 1 grant 2", wb_cyc, grant); end
    checks++; if (wb_adr !== 32'h0000_0100 || wb_dat !== 32'hCAFE_F00D || wb_we !== 1'b1 || wb_sel !== 4'hF) begin errors++; $display("FAIL wr_bus got adr %h dat %h we %0b sel %h exp 00000100 cafef00d 1 f", wb_adr, wb_dat, wb_we, wb_sel); end
    checks++; if (dbus_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack got %0b exp 0", dbus_ack); end
    step();
    wb_ack = 1'b1; wb_rdt = 32'h5555_AAAA;
    #1;
    checks++; if (wb_cyc !== 1'b1 || dbus_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got cyc %0b ack %0b exp 1 1", wb_cyc, dbus_ack); end
    checks++; if (ibus_ack !== 1'b0 || dma_ack !== 1'b0) begin errors++; $display("FAIL wr_other_ack got ibus %0b dma %0b exp 0 0", ibus_ack, dma_ack); end
    step();
    wb_ack = 1'b0; dbus_cyc = 1'b0;
    #1;
    checks++; if (wb_cyc !== 1'b0 || grant !== 2'd2 || dbus_ack !== 1'b0) begin errors++; $display("FAIL wr_release got cyc %0b grant %0d ack %0b exp 0 2 0", wb_cyc, grant, dbus_ack); end
    step();
    checks++; if (grant !== 2'd0 || wb_cyc !== 1'b0) begin errors++; $display("FAIL wr_idle got grant %0d cyc %0b exp 0 0", grant, wb_cyc); end
    $display("txn dbus write adr 00000100 dat cafef00d");
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_own [4];
    logic [31:0] exp_adr;
    logic [2:0]  exp_acks;
    exp_own[0] = 2'd1; exp_own[1] = 2'd2; exp_own[2] = 2'd3; exp_own[3] = 2'd1;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step();
    ibus_adr = 32'h0000_1000; dbus_adr = 32'h0000_2000; dma_adr = 32'h0000_3000;
    dbus_we = 1'b0; ibus_cyc = 1'b1; dbus_cyc = 1'b1; dma_cyc = 1'b1;
    wb_ack = 1'b1; wb_rdt = 32'h0BAD_F00D;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (grant !== 2'd0 || {dma_ack, dbus_ack, ibus_ack} !== 3'b000) begin errors++; $display("FAIL rr_idle%0d got grant %0d acks %b exp 0 000", n, grant, {dma_ack, dbus_ack, ibus_ack}); end
      step();
      exp_adr  = {16'h0, 2'b00, exp_own[n], 12'h000};
      exp_acks = 3'b001 << (exp_own[n] - 2'd1);
      checks++; if (grant !== exp_own[n] || wb_adr !== exp_adr) begin errors++; $display("FAIL rr_grant%0d got grant %0d adr %h exp %0d %h", n, grant, wb_adr, exp_own[n], exp_adr); end
      checks++; if ({dma_ack, dbus_ack, ibus_ack} !== exp_acks) begin errors++; $display("FAIL rr_ack%0d got %b exp %b", n, {dma_ack, dbus_ack, ibus_ack}, exp_acks); end
      step();
      checks++; if (wb_cyc !== 1'b0 || grant !== exp_own[n] || {dma_ack, dbus_ack, ibus_ack} !== 3'b000) begin errors++; $display("FAIL rr_release%0d got cyc %0b grant %0d acks %b exp 0 %0d 000", n, wb_cyc, grant, {dma_ack, dbus_ack, ibus_ack}, exp_own[n]); end
      step();
      $display("txn round-robin grant %0d", exp_own[n]);
    end
    ibus_cyc = 1'b0; dbus_cyc = 1'b0; dma_cyc = 1'b0; wb_ack = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    dma_adr = 32'h0000_4000; dma_we = 1'b0; dma_sel = 4'hF; dma_cyc = 1'b1;
    wb_rdt = 32'h1111_1111;
    step();
    for (int b = 1; b <= 3; b++) begin
      checks++; if (dma_ack !== 1'b0 || timeout !== 1'b0 || wb_cyc !== 1'b1) begin errors++; $display("FAIL to_wait%0d got ack %0b to %0b cyc %0b exp 0 0 1", b, dma_ack, timeout, wb_cyc); end
      step();
    end
    checks++; if (dma_ack !== 1'b1 || dma_rdt !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_ack got ack %0b rdt %h exp 1 deadbeef", dma_ack, dma_rdt); end
    checks++; if (timeout !== 1'b1 || wb_cyc !== 1'b0) begin errors++; $display("FAIL to_pulse got to %0b cyc %0b exp 1 0", timeout, wb_cyc); end
    step();
    dma_cyc = 1'b0;
    #1;
    checks++; if (timeout !== 1'b0 || timeout_cnt !== 8'd1 || dma_ack !== 1'b0) begin errors++; $display("FAIL to_after got to %0b cnt %0d ack %0b exp 0 1 0", timeout, timeout_cnt, dma_ack); end
    step();
    $display("txn dma read timeout");
  endtask

  task automatic test_ack_at_limit();
    dma_cyc = 1'b1;
    step();
    for (int b = 1; b <= 3; b++) begin
      checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL lim_wait%0d got ack %0b exp 0", b, dma_ack); end
      step();
    end
    wb_ack = 1'b1; wb_rdt = 32'h1234_5678;
    #1;
    checks++; if (dma_ack !== 1'b1 || dma_rdt !== 32'h1234_5678) begin errors++; $display("FAIL lim_ack got ack %0b rdt %h exp 1 12345678", dma_ack, dma_rdt); end
    checks++; if (timeout !== 1'b0 || wb_cyc !== 1'b1) begin errors++; $display("FAIL lim_no_to got to %0b cyc %0b exp 0 1", timeout, wb_cyc); end
    step();
    wb_ack = 1'b0; dma_cyc = 1'b0;
    #1;
    checks++; if (timeout_cnt !== 8'd1 || grant !== 2'd3) begin errors++; $display("FAIL lim_cnt got cnt %0d grant %0d exp 1 3", timeout_cnt, grant); end
    step();
    $display("txn dma read ack at limit");
  endtask

  task automatic test_abort();
    ibus_adr = 32'h0000_5000; dbus_adr = 32'h0000_6000;
    ibus_cyc = 1'b1; dbus_cyc = 1'b1;
    step();
    checks++; if (grant !== 2'd1 || wb_cyc !== 1'b1 || ibus_ack !== 1'b0) begin errors++; $display("FAIL ab_busy got grant %0d cyc %0b ack %0b exp 1 1 0", grant, wb_cyc, ibus_ack); end
    step();
    ibus_cyc = 1'b0;
    #1;
    checks++; if (wb_cyc !== 1'b0 || ibus_ack !== 1'b0) begin errors++; $display("FAIL ab_drop got cyc %0b ack %0b exp 0 0", wb_cyc, ibus_ack); end
    step();
    checks++; if (grant !== 2'd0 || wb_cyc !== 1'b0) begin errors++; $display("FAIL ab_idle got grant %0d cyc %0b exp 0 0", grant, wb_cyc); end
    step();
    checks++; if (grant !== 2'd2 || wb_adr !== 32'h0000_6000) begin errors++; $display("FAIL ab_next got grant %0d adr %h exp 2 00006000", grant, wb_adr); end
    wb_ack = 1'b1;
    #1;
    checks++; if (dbus_ack !== 1'b1) begin errors++; $display("FAIL ab_next_ack got %0b exp 1", dbus_ack); end
    step();
    wb_ack = 1'b0; dbus_cyc = 1'b0;
    step();
    $display("txn ibus abort then dbus");
  endtask

  task automatic test_reset_mid();
    dbus_cyc = 1'b1;
    step();
    checks++; if (grant !== 2'd2 || wb_cyc !== 1'b1) begin errors++; $display("FAIL rm_busy got grant %0d cyc %0b exp 2 1", grant, wb_cyc); end
    rst_n = 1'b0; wb_ack = 1'b1;
    #1;
    checks++; if (wb_cyc !== 1'b0 || {ibus_ack, dbus_ack, dma_ack} !== 3'b000 || grant !== 2'd0) begin errors++; $display("FAIL rm_async got cyc %0b acks %b grant %0d exp 0 000 0", wb_cyc, {ibus_ack, dbus_ack, dma_ack}, grant); end
    checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("FAIL rm_tcnt got %0d exp 0", timeout_cnt); end
    wb_ack = 1'b0; ibus_cyc = 1'b1; dma_cyc = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL rm_idle got grant %0d exp 0", grant); end
    step();
    checks++; if (grant !== 2'd1) begin errors++; $display("FAIL rm_tie got grant %0d exp 1", grant); end
    ibus_cyc = 1'b0; dbus_cyc = 1'b0; dma_cyc = 1'b0;
    step();
    step();
    $display("txn reset mid-busy");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_timeout();
    test_ack_at_limit();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
